// File: rtl/prog_counter.sv
// Prescaled up/down counter with load, programmable modulus, wrap/saturate
// mode, terminal-count pulse and sticky overflow flag. Single clock domain.
// Optional feature macro: PROG_COUNTER_STEP_EN adds a 'step' input that forces
// one count update independent of en and the prescaler.
module prog_counter #(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 16,
    parameter int unsigned DIV_MAX = 50_000_000,
    parameter int unsigned DIV_W   = 26
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    input  logic             up,
    input  logic             sat,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
`ifdef PROG_COUNTER_STEP_EN
    input  logic             step,
`endif
    output logic [WIDTH-1:0] out,
    output logic             tick,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_MAX - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             tick_i;
    logic             step_i;
    logic             upd;
    logic             at_end;
    logic [WIDTH-1:0] next_out;
    logic [WIDTH-1:0] load_clamped;

    assign tick_i = en && (div_cnt == DIV_LAST);

`ifdef PROG_COUNTER_STEP_EN
    assign step_i = step;
`else
    assign step_i = 1'b0;
`endif

    // A step coincident with a prescaler tick still yields a single update.
    assign upd    = tick_i | step_i;
    assign at_end = up ? (out == MAX_VAL) : (out == '0);

    // Clamp out-of-range load values to the top of the count range.
    assign load_clamped = ({1'b0, load_val} < MOD_EXT) ? load_val : MAX_VAL;

    // Next count for an update: step within range, else wrap or hold at the end.
    always_comb begin
        next_out = out;
        if (at_end) begin
            if (!sat) begin
                next_out = up ? '0 : MAX_VAL;
            end
        end else begin
            next_out = up ? out + WIDTH'(1) : out - WIDTH'(1);
        end
    end

    // Prescaler: runs while enabled, restarts on load, holds while disabled.
    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt <= '0;
        end else if (load) begin
            div_cnt <= '0;
        end else if (en) begin
            div_cnt <= tick_i ? '0 : div_cnt + DIV_W'(1);
        end
    end

    // Count register, tick/tc pulses and sticky overflow; load beats update.
    always_ff @(posedge clk) begin
        if (clr) begin
            out  <= '0;
            tick <= 1'b0;
            tc   <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            tick <= 1'b0;
            tc   <= 1'b0;
            if (load) begin
                out <= load_clamped;
            end else if (upd) begin
                out  <= next_out;
                tick <= 1'b1;
                tc   <= at_end;
            end
            if (upd && !load && at_end) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_prog_counter.sv
// Bench for prog_counter: a cycle model of the counting rules checked every
// cycle on the DIV_MAX=4 instance, plus directed literal checks on both the
// DIV_MAX=4 and DIV_MAX=1 instances.
module tb_prog_counter;

    localparam int unsigned W  = 4;
    localparam int unsigned M  = 10;
    localparam int unsigned DM = 4;

    logic         clk = 1'b0;
    logic         clr, en, up, sat, load, ovf_clr;
    logic [W-1:0] load_val;
    logic [W-1:0] out;
    logic         tick, tc, ovf;

    logic         clr1, en1, step1;
    logic [W-1:0] out1;
    logic         tick1, tc1, ovf1;

    int n_assert = 0;
    int n_fail   = 0;
    bit chk_on   = 1'b0;

    int m_cnt, m_phase;
    bit m_tick, m_tc, m_ovf;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(W), .MODULUS(M), .DIV_MAX(DM), .DIV_W(3)) u_dut (
        .clk(clk), .clr(clr), .en(en), .up(up), .sat(sat), .load(load),
        .load_val(load_val), .ovf_clr(ovf_clr),
`ifdef PROG_COUNTER_STEP_EN
        .step(1'b0),
`endif
        .out(out), .tick(tick), .tc(tc), .ovf(ovf)
    );

    prog_counter #(.WIDTH(W), .MODULUS(M), .DIV_MAX(1), .DIV_W(1)) u_dut1 (
        .clk(clk), .clr(clr1), .en(en1), .up(1'b1), .sat(1'b0), .load(1'b0),
        .load_val(4'd0), .ovf_clr(1'b0),
`ifdef PROG_COUNTER_STEP_EN
        .step(step1),
`endif
        .out(out1), .tick(tick1), .tc(tc1), .ovf(ovf1)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_assert++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: count kept as an integer in 0..M-1, modular arithmetic.
    always @(posedge clk) begin
        bit due, boundary;
        if (clr) begin
            m_cnt = 0; m_phase = 0; m_tick = 0; m_tc = 0; m_ovf = 0;
        end else begin
            due = en && (m_phase == DM - 1);
            if (en) m_phase = due ? 0 : m_phase + 1;
            m_tick = 0;
            m_tc   = 0;
            if (load) begin
                m_cnt   = (int'(load_val) < M) ? int'(load_val) : M - 1;
                m_phase = 0;
            end else if (due) begin
                m_tick   = 1;
                boundary = up ? (m_cnt == M - 1) : (m_cnt == 0);
                m_tc     = boundary;
                if (!(boundary && sat))
                    m_cnt = up ? (m_cnt + 1) % M : (m_cnt + M - 1) % M;
            end
            if (m_tc) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
        end
    end

    // Every-cycle comparison of the DIV_MAX=4 instance against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_out",  int'(out),  m_cnt);
            chk("model_tick", int'(tick), int'(m_tick));
            chk("model_tc",   int'(tc),   int'(m_tc));
            chk("model_ovf",  int'(ovf),  int'(m_ovf));
        end
    end

    initial begin
        clr = 1; en = 0; up = 0; sat = 0; load = 0; load_val = '0; ovf_clr = 0;
        clr1 = 1; en1 = 0; step1 = 0;

        // Reset
        repeat (2) @(negedge clk);
        chk("rst_out", int'(out), 0);  chk("rst_tick", int'(tick), 0);
        chk("rst_tc", int'(tc), 0);    chk("rst_ovf", int'(ovf), 0);

        // Free-run up/wrap
        clr = 0; chk_on = 1; en = 1; up = 1; sat = 0;
        repeat (4) @(negedge clk);
        chk("run_first_out", int'(out), 1); chk("run_first_tick", int'(tick), 1);
        @(negedge clk);
        chk("run_tick_pulse", int'(tick), 0);
        repeat (35) @(negedge clk);
        chk("wrap_out", int'(out), 0); chk("wrap_tc", int'(tc), 1);
        chk("wrap_ovf", int'(ovf), 1);
        @(negedge clk);
        chk("wrap_tc_pulse", int'(tc), 0);

        // Down/saturate, with ovf cleared during the load
        load = 1; load_val = 4'd2; up = 0; sat = 1; ovf_clr = 1;
        @(negedge clk);
        chk("ld2_out", int'(out), 2); chk("ld2_ovf", int'(ovf), 0);
        load = 0; ovf_clr = 0;
        repeat (4) @(negedge clk);
        chk("dn_out1", int'(out), 1);
        repeat (4) @(negedge clk);
        chk("dn_out0", int'(out), 0); chk("dn_tc0", int'(tc), 0);
        repeat (4) @(negedge clk);
        chk("sat_out", int'(out), 0); chk("sat_tc", int'(tc), 1);
        chk("sat_ovf", int'(ovf), 1);
        repeat (3) @(negedge clk);
        ovf_clr = 1;
        @(negedge clk);
        chk("setwin_tc", int'(tc), 1); chk("setwin_ovf", int'(ovf), 1);
        @(negedge clk);
        chk("ovfclr_ovf", int'(ovf), 0);
        ovf_clr = 0;

        // Load clamp, then load on the tick_i cycle
        load = 1; load_val = 4'd15;
        @(negedge clk);
        chk("clamp_out", int'(out), 9);
        load = 0;
        repeat (3) @(negedge clk);
        load = 1; load_val = 4'd5;
        @(negedge clk);
        chk("ldtick_out", int'(out), 5); chk("ldtick_tick", int'(tick), 0);
        chk("ldtick_tc", int'(tc), 0);
        load = 0;
        repeat (3) @(negedge clk);
        chk("ldtick_wait", int'(tick), 0);
        @(negedge clk);
        chk("ldtick_next_tick", int'(tick), 1); chk("ldtick_next_out", int'(out), 4);

        // Enable gating: 7 idle cycles stretch the period to 11
        repeat (2) @(negedge clk);
        en = 0;
        repeat (7) @(negedge clk);
        chk("gate_hold_out", int'(out), 4);
        en = 1;
        @(negedge clk);
        chk("gate_tick0", int'(tick), 0);
        @(negedge clk);
        chk("gate_tick1", int'(tick), 1); chk("gate_out", int'(out), 3);

        // Mid-operation reset with ovf set and tick_i due
        load = 1; load_val = 4'd0; up = 0; sat = 0;
        @(negedge clk);
        load = 0;
        repeat (4) @(negedge clk);
        chk("dnwrap_out", int'(out), 9); chk("dnwrap_ovf", int'(ovf), 1);
        up = 1; load = 1; load_val = 4'd5;
        @(negedge clk);
        chk("pre_clr_out", int'(out), 5);
        load = 0;
        repeat (3) @(negedge clk);
        clr = 1;
        @(negedge clk);
        chk("mclr_out", int'(out), 0); chk("mclr_tick", int'(tick), 0);
        chk("mclr_tc", int'(tc), 0);   chk("mclr_ovf", int'(ovf), 0);
        clr = 0;
        repeat (3) @(negedge clk);
        chk("mclr_wait_tick", int'(tick), 0);
        @(negedge clk);
        chk("mclr_first_out", int'(out), 1); chk("mclr_first_tick", int'(tick), 1);

        // DIV_MAX=1: a tick every enabled cycle
        clr1 = 0; en1 = 1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            chk("d1_out", int'(out1), k % 10);
            chk("d1_tick", int'(tick1), 1);
        end
        en1 = 0;
        @(negedge clk);
        chk("d1_stop_tick", int'(tick1), 0); chk("d1_stop_out", int'(out1), 2);
`ifdef PROG_COUNTER_STEP_EN
        for (int k = 1; k <= 3; k++) begin
            step1 = 1;
            @(negedge clk);
            chk("step_out", int'(out1), 2 + k); chk("step_tick", int'(tick1), 1);
            step1 = 0;
            @(negedge clk);
            chk("step_idle_out", int'(out1), 2 + k); chk("step_idle_tick", int'(tick1), 0);
        end
        en1 = 1; step1 = 1;
        @(negedge clk);
        chk("step_coinc_out", int'(out1), 6);
        en1 = 0; step1 = 0;
        @(negedge clk);
        chk("step_coinc_hold", int'(out1), 6);
`endif

        chk_on = 0;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_counter.md
Name: prog_counter

Overview:
- Parametrised prescaled up/down counter; successor to the fixed 4-bit, 0.5 s hex counter used on the Basys3 display path.
- Prescaler produces a one-cycle enable tick; the counter advances on that tick.
- Fully single-clock: no derived clock is used anywhere.
- Adds direction, load, programmable modulus, wrap/saturate mode, terminal-count pulse and sticky overflow flag.
- Feeds the seven-segment/ALU operand path; typically instanced at clk = 100 MHz.

Parameters:
- WIDTH, 4: count width in bits.
- MODULUS, 16: count range is 0..MODULUS-1. Legal range 2..2^WIDTH.
- DIV_MAX, 50_000_000: clk cycles per tick. Must be >=1; 1 means a tick every enabled cycle.
- DIV_W, 26: prescaler width. Requires 2^DIV_W >= DIV_MAX.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  reset: synchronous, active-high.
- en  in  1  run enable. Gates the prescaler and the counter.
- up  in  1  1 = count up, 0 = count down. Sampled on the tick cycle.
- sat  in  1  1 = saturate at the ends, 0 = wrap.
- load  in  1  synchronous load strobe.
- load_val  in  WIDTH  value to load.
- ovf_clr  in  1  clears the sticky ovf flag.
- out  out  WIDTH  current count, registered.
- tick  out  1  registered one-cycle pulse; high in the cycle out shows the post-tick value.
- tc  out  1  registered one-cycle pulse on the wrap/saturate boundary event.
- ovf  out  1  sticky boundary flag.

Behaviour:
- Reset: when clr=1 at a rising edge, out=0, tick=0, tc=0, ovf=0 and prescaler=0 from the next cycle. clr overrides every other input.
- Prescaler:
  - With en=1, div_cnt increments each cycle. When div_cnt==DIV_MAX-1 it returns to 0 and internal tick_i=1 that cycle.
  - With en=0, div_cnt holds and tick_i=0.
- Count update priority at each edge is clr > load > tick_i.
- load=1:
  - out <= load_val if load_val<MODULUS, otherwise MODULUS-1.
  - div_cnt <= 0. tick and tc are 0 next cycle, even if tick_i was due. load works regardless of en.
- tick_i=1, up=1:
  - If out<MODULUS-1: out+1.
  - At MODULUS-1: with sat=0, out <= 0; with sat=1, out holds. In both cases tc=1 next cycle and ovf is set.
- tick_i=1, up=0:
  - If out>0: out-1.
  - At 0: with sat=0, out <= MODULUS-1; with sat=1, out holds. In both cases tc=1 and ovf is set.
- Latency: out, tick and tc update 1 cycle after tick_i. tick and tc are never high for more than 1 consecutive cycle unless DIV_MAX=1.
- ovf:
  - Set by any boundary event; held until ovf_clr=1.
  - Set and ovf_clr in the same cycle: set wins.
- Changing up, sat or MODULUS-relevant inputs mid-period takes effect on the next tick_i. There is no pipeline hazard.
- Arithmetic is modulo MODULUS, never 2^WIDTH. No output ever holds a value >=MODULUS.

Optional Feature:
- Macro: PROG_COUNTER_STEP_EN.
- When defined:
  - Adds input port step (1 bit).
  - step=1 with load=0 forces one count update exactly as tick_i would, independent of en and the prescaler. This includes tick, tc and ovf effects.
  - div_cnt is not reset by step.
  - step coincident with tick_i yields a single update, not two.
- When undefined: no step port. Counting occurs only via the prescaler.

Test Plan (MODULUS=10, DIV_MAX=4, WIDTH=4 unless stated):
- Reset and free-run: clr 2 cycles, then en=1, up=1, sat=0.
  - out steps 0,1,2… every 4 cycles, with a tick pulse each step.
  - After 9 comes 0, with tc=1 for 1 cycle and ovf=1.
- Down/saturate: load_val=2, load=1, then up=0, sat=1.
  - out goes 2,1,0,0,0. tc pulses at each tick while at 0; ovf=1.
  - ovf_clr=1 on the same cycle as a tc event: ovf stays 1.
- Load clamp and priority:
  - load_val=15 → out=9.
  - load asserted on the tick_i cycle → out=load_val, no tick/tc, next tick 4 cycles later.
- Enable gating: deassert en for 7 cycles mid-period. The period resumes at the held div_cnt, and the total cycles between ticks equal 4+7.
- Mid-operation reset: clr at out=5 while tick_i is due → out=0, tick=0, tc=0, ovf=0, and div_cnt restarts from 0.
- DIV_MAX=1 with PROG_COUNTER_STEP_EN:
  - With en=1, out increments every cycle and tick is held high.
  - With en=0, step pulses advance out by exactly one each.
